// File: rtl/quant_multi_pred.sv
// quant_multi_pred: best-fit multi-predictor residual quantizer with ready/valid flow control.
// Optional macro QUANT_VERIFY_EN adds a final stage rechecking |data - recon| <= eb.
module quant_multi_pred #(
  parameter int WIDTH = 32,
  parameter int QUANT = 13,
  parameter int NPRED = 3,
  parameter int FRAC  = 16,
  parameter int ENC_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_load,
  input  logic [WIDTH-1:0]       cfg_eb,
  input  logic [FRAC:0]          cfg_inv2eb,
  input  logic [NPRED-1:0]       pred_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [NPRED*WIDTH-1:0] pred_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [QUANT:0]         quant_code,
  output logic [ENC_W-1:0]       encode_out,
  output logic [WIDTH-1:0]       prediction_out,
  output logic [31:0]            unpred_cnt,
  input  logic                   cnt_clr
);
  localparam int DW    = WIDTH + 1;
  localparam int PW    = DW + FRAC + 1;
  localparam int RW    = WIDTH + QUANT + 2;
  localparam int SEL_W = (NPRED > 1) ? $clog2(NPRED) : 1;
  localparam logic [PW:0] RND = {{(PW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  function automatic logic signed [DW-1:0] sub_ext(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
    return $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
  endfunction

  function automatic logic [DW-1:0] abs_diff(input logic signed [DW-1:0] d);
    return d[DW-1] ? $unsigned(-d) : $unsigned(d);
  endfunction

  // Round half up on the magnitude; the upper FRAC bits of the result are always zero.
  function automatic logic [PW:0] round_mag(input logic [PW-1:0] p);
    return ({1'b0, p} + RND) >> FRAC;
  endfunction

  function automatic logic code_ovf(input logic [PW:0] m);
    return |m[PW:QUANT];
  endfunction

  function automatic logic signed [RW-1:0] recon_calc(input logic signed [WIDTH-1:0] p,
                                                      input logic signed [QUANT:0]   c,
                                                      input logic [WIDTH-1:0]        eb);
    logic signed [RW-1:0] p_x, c_x, step;
    p_x  = $signed({{(RW-WIDTH){p[WIDTH-1]}}, p});
    c_x  = $signed({{(RW-QUANT-1){c[QUANT]}}, c});
    step = $signed({{(RW-WIDTH-1){1'b0}}, eb, 1'b0});
    return p_x + c_x * step;
  endfunction

  function automatic logic fits_width(input logic signed [RW-1:0] r);
    return (&r[RW-1:WIDTH-1]) | ~(|r[RW-1:WIDTH-1]);
  endfunction

  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  logic [WIDTH-1:0] eb_r;
  logic [FRAC:0]    inv_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eb_r  <= '0;
      inv_r <= '0;
    end else if (cfg_load) begin
      eb_r  <= cfg_eb;
      inv_r <= cfg_inv2eb;
    end
  end

  logic vld_p1, vld_p2, vld_p3, vld_p4;
  logic signed [DW-1:0]    diff_c [NPRED];
  logic signed [WIDTH-1:0] data_p1, data_p2, data_p3, data_p4;
  logic signed [WIDTH-1:0] pred_p1 [NPRED];
  logic signed [DW-1:0]    diff_p1 [NPRED];
  logic [NPRED-1:0]        en_p1;
  logic [WIDTH-1:0]        eb_p1, eb_p2, eb_p3, eb_p4;
  logic [FRAC:0]           inv_p1, inv_p2;
  logic                    found_c, neg_c;
  logic [SEL_W-1:0]        sel_c, sel_p2, sel_p3, sel_p4;
  logic [DW-1:0]           best_c, mag_p2;
  logic signed [WIDTH-1:0] psel_c, psel_p2, psel_p3, psel_p4;
  logic                    unp_p2, unp_p3, unp_p4, neg_p2, neg_p3;
  logic [PW-1:0]           prod_p3;
  logic [PW:0]             mag_c;
  logic signed [QUANT:0]   code_c, code_p4;
  logic signed [RW-1:0]    recon_c;
  logic                    res_unp_c;
  logic [QUANT:0]          res_code_c;
  logic [ENC_W-1:0]        res_enc_c;
  logic [WIDTH-1:0]        res_pred_c;

  always_comb begin
    for (int i = 0; i < NPRED; i++)
      diff_c[i] = sub_ext(data_in, pred_in[i*WIDTH +: WIDTH]);
  end

  // Minimum |d| over enabled predictors; strict < keeps the lowest index on ties.
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    best_c  = '0;
    neg_c   = 1'b0;
    psel_c  = pred_p1[0];
    for (int i = 0; i < NPRED; i++) begin
      if (en_p1[i] && (!found_c || abs_diff(diff_p1[i]) < best_c)) begin
        found_c = 1'b1;
        sel_c   = SEL_W'(i);
        best_c  = abs_diff(diff_p1[i]);
        neg_c   = diff_p1[i][DW-1];
        psel_c  = pred_p1[i];
      end
    end
  end

  assign mag_c  = round_mag(prod_p3);
  assign code_c = neg_p3 ? -$signed({1'b0, mag_c[QUANT-1:0]}) : $signed({1'b0, mag_c[QUANT-1:0]});

  assign recon_c    = recon_calc(psel_p4, code_p4, eb_p4);
  assign res_unp_c  = unp_p4 | ~fits_width(recon_c);
  assign res_code_c = res_unp_c ? '0 : code_p4;
  assign res_enc_c  = res_unp_c ? '0 : ENC_W'(sel_p4) + ENC_W'(1);
  assign res_pred_c = res_unp_c ? data_p4 : recon_c[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      // S1: capture sample, per-sample config copy and raw residuals
      data_p1 <= data_in;
      en_p1   <= pred_en;
      eb_p1   <= eb_r;
      inv_p1  <= inv_r;
      for (int i = 0; i < NPRED; i++) begin
        pred_p1[i] <= pred_in[i*WIDTH +: WIDTH];
        diff_p1[i] <= diff_c[i];
      end
      // S2: best-fit predictor
      unp_p2  <= ~found_c;
      sel_p2  <= sel_c;
      mag_p2  <= best_c;
      neg_p2  <= neg_c;
      psel_p2 <= psel_c;
      data_p2 <= data_p1;
      eb_p2   <= eb_p1;
      inv_p2  <= inv_p1;
      // S3: scale by the reciprocal of 2*eb
      prod_p3 <= PW'(mag_p2) * PW'(inv_p2);
      unp_p3  <= unp_p2;
      sel_p3  <= sel_p2;
      neg_p3  <= neg_p2;
      psel_p3 <= psel_p2;
      data_p3 <= data_p2;
      eb_p3   <= eb_p2;
      // S4: rounded signed code with overflow detection
      code_p4 <= code_c;
      unp_p4  <= unp_p3 | code_ovf(mag_c);
      sel_p4  <= sel_p3;
      psel_p4 <= psel_p3;
      data_p4 <= data_p3;
      eb_p4   <= eb_p3;
    end
  end

`ifdef QUANT_VERIFY_EN
  logic                    vld_p5;
  logic [QUANT:0]          code_p5;
  logic [ENC_W-1:0]        enc_p5;
  logic signed [WIDTH-1:0] pred_p5, data_p5;
  logic [WIDTH-1:0]        eb_p5;
  logic [DW-1:0]           err_c;
  logic                    bad_c;

  // Unpredictable samples already carry pred == data, so their error is zero.
  assign err_c = abs_diff(sub_ext(data_p5, pred_p5));
  assign bad_c = err_c > {1'b0, eb_p5};

  // S5: reconstruction registered for the check stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_p5 <= 1'b0;
    else if (adv)
      vld_p5 <= vld_p4;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      code_p5 <= res_code_c;
      enc_p5  <= res_enc_c;
      pred_p5 <= res_pred_c;
      data_p5 <= data_p4;
      eb_p5   <= eb_p4;
    end
  end

  // S6: error-bound check and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      quant_code     <= '0;
      encode_out     <= '0;
      prediction_out <= '0;
    end else if (adv) begin
      out_valid      <= vld_p5;
      quant_code     <= bad_c ? '0 : code_p5;
      encode_out     <= bad_c ? '0 : enc_p5;
      prediction_out <= bad_c ? data_p5 : pred_p5;
    end
  end
`else
  // S5: reconstruction, range check and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      quant_code     <= '0;
      encode_out     <= '0;
      prediction_out <= '0;
    end else if (adv) begin
      out_valid      <= vld_p4;
      quant_code     <= res_code_c;
      encode_out     <= res_enc_c;
      prediction_out <= res_pred_c;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      unpred_cnt <= '0;
    else if (cnt_clr)
      unpred_cnt <= '0;
    else if (out_valid && out_ready && encode_out == '0 && unpred_cnt != '1)
      unpred_cnt <= unpred_cnt + 32'd1;
  end

endmodule

// File: doc/quant_multi_pred.md
Name: quant_multi_pred

Overview:
- Fixed-point successor to the single-model float quantizer in the SZ first stages.
- Takes one signed fixed-point sample plus up to NPRED candidate predictions per cycle and selects the best-fit predictor (smallest residual).
- Quantizes the residual against a runtime error bound and emits quant code, encode tag, reconstructed prediction and out_valid.
- Adds ready/valid backpressure, per-predictor enable, an unpredictable-sample counter and runtime config load.

Parameters:
- WIDTH, 32: data/prediction width, signed two's complement.
- QUANT, 13: code magnitude bits; quant_code is QUANT+1 bits, two's complement.
- NPRED, 3: number of candidate predictors, range 1..3.
- FRAC, 16: fractional bits of the reciprocal inv2eb.
- ENC_W, 2: encode tag width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_load  in  1  pulse: capture cfg_eb and cfg_inv2eb
- cfg_eb  in  WIDTH  error bound eb, unsigned, integer units
- cfg_inv2eb  in  FRAC+1  round(2^FRAC/(2*eb)), unsigned
- pred_en  in  NPRED  per-predictor enable
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept
- data_in  in  WIDTH  sample
- pred_in  in  NPRED*WIDTH  predictions; predictor i at [i*WIDTH +: WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- quant_code  out  QUANT+1  signed code
- encode_out  out  ENC_W  00 unpredictable; i+1 = predictor i
- prediction_out  out  WIDTH  reconstructed value
- unpred_cnt  out  32  saturating count of unpredictable outputs
- cnt_clr  in  1  synchronous clear of unpred_cnt

Behaviour:
- Reset: all outputs 0, all pipeline valids 0, config registers 0.
- Pipeline advance: enabled when stall = out_valid & ~out_ready is 0.
  - in_ready = ~stall.
  - A sample is accepted when in_valid & in_ready.
  - Bubbles are not collapsed.
  - Under stall every stage holds and the outputs stay stable.
- Latency: 5 advancing cycles from accept to out_valid (6 with QUANT_VERIFY_EN).
- S1: register data; d_i = data - pred_i, computed at WIDTH+1 bits.
- S2: |d_i| for enabled predictors; select minimum, ties to lowest index. If pred_en == 0, the sample is unpredictable.
- S3: p = |d_sel| * inv2eb, full product width.
- S4: mag = (p + 2^(FRAC-1)) >> FRAC, i.e. round half up on magnitude.
  - If mag > 2^QUANT - 1: unpredictable.
  - Otherwise code = sign(d_sel) ? -mag : mag.
- S5: recon = pred_sel + code*(eb<<1), at WIDTH+QUANT+2 bits.
  - If recon lies outside the signed WIDTH range: unpredictable.
- Outputs at S5:
  - Normal sample: quant_code = code, encode_out = sel+1, prediction_out = recon.
  - Unpredictable sample: quant_code = 0, encode_out = 00, prediction_out = data (lossless passthrough).
- Config:
  - cfg_load updates eb and inv2eb at the clock edge.
  - A sample accepted in the same cycle as cfg_load uses the old values.
  - Each sample carries its own eb/inv2eb copy through the pipe, so a config change never corrupts samples in flight.
- Counter:
  - unpred_cnt increments once per unpredictable out_valid & out_ready handshake and saturates at 2^32-1.
  - cnt_clr wins over a simultaneous increment (result 0).
- Reset mid-operation: every in-flight sample is discarded, no output is produced for it, and unpred_cnt clears.

Optional Feature:
- Macro: QUANT_VERIFY_EN.
- When defined:
  - Adds stage S6 computing |data - recon|.
  - If the result exceeds eb, the sample is forced unpredictable (code 0, enc 00, prediction_out = data).
  - Latency becomes 6.
- When undefined: no check stage and latency is 5.

Test Plan:
- Best-fit select:
  - Stimulus: eb=4, inv2eb=8192, data=100, preds {90,150,101}, pred_en=111.
  - Required response: enc=11, code=0, prediction_out=101, 5 cycles after accept.
- Exact quant:
  - Stimulus: data=100, preds {60,x,x}, pred_en=001.
  - Required response: enc=01, code=5, prediction_out=100.
- Negative rounding:
  - Stimulus: data=0, pred0=20, pred_en=001.
  - Required response: code=-3, prediction_out=-4; with QUANT_VERIFY_EN still predictable (error 4 ≤ eb).
- Overflow:
  - Stimulus: data=65536, pred0=0.
  - Required response: mag=8192 > 8191, so enc=00, code=0, prediction_out=65536, unpred_cnt=1.
  - Follow-up: pred_en=000 gives unpredictable again, unpred_cnt=2.
- Backpressure:
  - Stimulus: 10 back-to-back samples, out_ready low for 3 cycles mid-stream.
  - Required response: in_ready low exactly while stalled, outputs held, all 10 results in order with no loss or duplication.
- Config and reset:
  - Stimulus: cfg_load in the same cycle as an accept.
  - Required response: that sample uses the old eb and the next sample the new eb.
  - Stimulus: assert rst with 3 samples in flight.
  - Required response: out_valid=0 and unpred_cnt=0 immediately, and no stale output appears after release.
